bcm_row_shifter: RTL and testbench

Downstream pixel-shift stage for the LED matrix driver. On each start pulse it reads one row pair (top half and bottom half) from the frame RAM, one column at a time. For every pixel it selects the colour bit addressed by the driver's current BCM bit. It then shifts that bit onto the panel's six data lines (R1 G1 B1 R2 G2 B2) together with a panel shift clock, and pulses `done` so the driver can latch the row.

---
 rtl/bcm_row_shifter.sv | 171 +++++++++++++++++
 tb/tb_bcm_row_shifter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_row_shifter.sv
// bcm_row_shifter
// Reads one row pair (top and bottom bank) from the frame RAM, one column at a
// time. For each pixel it picks the colour bit for the current BCM plane and
// shifts it onto the panel data lines. A panel shift clock runs alongside the
// data, and done pulses once the last column has been clocked.
//
// Ports:
//   clk, n_rst        - clock, asynchronous active-low reset
//   start             - one-cycle shift request (ignored unless idle)
//   mux_val           - row-pair index, latched at start
//   current_bcm_bit   - colour bit plane to display, latched at start
//   rd_addr           - frame RAM address {row, col}, shared by both banks
//   rd_data_top/bot   - pixel {R,G,B} from each bank, one-cycle read latency
//   rgb1, rgb2        - {R,G,B} panel data for top / bottom half
//   panel_clk         - panel shift clock (data sampled on its rising edge)
//   busy              - shift in progress (PRIME through last HI)
//   done              - one-cycle pulse after the final column
//
// Build option: define LED_SHIFT_REVERSE_EN to fetch columns from
// MATRIX_WIDTH-1 down to 0 instead of 0 up to MATRIX_WIDTH-1.
module bcm_row_shifter #(
  parameter int unsigned MATRIX_WIDTH  = 64,
  parameter int unsigned MATRIX_HEIGHT = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MUX_LENGTH    = 4,
  parameter int unsigned COL_BITS      = 6
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic [MUX_LENGTH-1:0]          mux_val,
  input  logic [DATA_WIDTH-1:0]          current_bcm_bit,
  output logic [MUX_LENGTH+COL_BITS-1:0] rd_addr,
  input  logic [3*DATA_WIDTH-1:0]        rd_data_top,
  input  logic [3*DATA_WIDTH-1:0]        rd_data_bot,
  output logic [2:0]                     rgb1,
  output logic [2:0]                     rgb2,
  output logic                           panel_clk,
  output logic                           busy,
  output logic                           done
);

  if ((MATRIX_HEIGHT / 2) != (1 << MUX_LENGTH)) begin : g_bad_height
    $error("MATRIX_HEIGHT/2 must equal 2**MUX_LENGTH");
  end
  if (MATRIX_WIDTH > (1 << COL_BITS)) begin : g_bad_width
    $error("MATRIX_WIDTH does not fit in COL_BITS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(MATRIX_WIDTH - 1);

`ifdef LED_SHIFT_REVERSE_EN
  localparam logic [COL_BITS-1:0] FC_FIRST = COL_LAST;

  function automatic logic [COL_BITS-1:0] fc_step(input logic [COL_BITS-1:0] fc);
    return (fc == '0) ? COL_LAST : fc - COL_BITS'(1);
  endfunction
`else
  localparam logic [COL_BITS-1:0] FC_FIRST = '0;

  function automatic logic [COL_BITS-1:0] fc_step(input logic [COL_BITS-1:0] fc);
    return (fc == COL_LAST) ? '0 : fc + COL_BITS'(1);
  endfunction
`endif

  // Out-of-range bit indices fall through the loop and yield all zeros.
  function automatic logic [2:0] sel_bits(input logic [3*DATA_WIDTH-1:0] d,
                                          input logic [DATA_WIDTH-1:0]   b);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (b == DATA_WIDTH'(i)) begin
        r = {d[2*DATA_WIDTH+i], d[DATA_WIDTH+i], d[i]};
      end
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [MUX_LENGTH-1:0]   row_q,   row_d;
  logic [DATA_WIDTH-1:0]   bit_q,   bit_d;
  logic [COL_BITS-1:0]     fc_q,    fc_d;
  // Counts displayed columns independently of fetch order so the last-column
  // test is identical in both builds.
  logic [COL_BITS-1:0]     cnt_q,   cnt_d;
  logic [2:0]              rgb1_q,  rgb1_d;
  logic [2:0]              rgb2_q,  rgb2_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      bit_q   <= '0;
      fc_q    <= '0;
      cnt_q   <= '0;
      rgb1_q  <= '0;
      rgb2_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bit_q   <= bit_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
      rgb1_q  <= rgb1_d;
      rgb2_q  <= rgb2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bit_d   = bit_q;
    fc_d    = fc_q;
    cnt_d   = cnt_q;
    rgb1_d  = rgb1_q;
    rgb2_d  = rgb2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = mux_val;
          bit_d   = current_bcm_bit;
          fc_d    = FC_FIRST;
          cnt_d   = '0;
          state_d = S_PRIME;
        end
      end
      S_PRIME: state_d = S_WAIT;
      S_WAIT: begin
        rgb1_d  = sel_bits(rd_data_top, bit_q);
        rgb2_d  = sel_bits(rd_data_bot, bit_q);
        fc_d    = fc_step(fc_q);
        state_d = S_LO;
      end
      S_LO: state_d = S_HI;
      S_HI: begin
        if (cnt_q == COL_LAST) begin
          // Data held through this HI; cleared so it reads 0 during DONE.
          rgb1_d  = '0;
          rgb2_d  = '0;
          state_d = S_DONE;
        end else begin
          rgb1_d  = sel_bits(rd_data_top, bit_q);
          rgb2_d  = sel_bits(rd_data_bot, bit_q);
          fc_d    = fc_step(fc_q);
          cnt_d   = cnt_q + COL_BITS'(1);
          state_d = S_LO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr   = {row_q, fc_q};
  assign rgb1      = rgb1_q;
  assign rgb2      = rgb2_q;
  assign panel_clk = (state_q == S_HI);
  assign busy      = (state_q == S_PRIME) || (state_q == S_WAIT) ||
                     (state_q == S_LO)    || (state_q == S_HI);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_bcm_row_shifter.sv
module tb_bcm_row_shifter;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int DW = 8;
  localparam int ML = 4;
  localparam int CB = 6;
  localparam int AW = ML + CB;
  localparam int DONE_CYC = 3 + 2 * W;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [ML-1:0] mux_val;
  logic [DW-1:0] current_bcm_bit;
  logic [AW-1:0] rd_addr;
  logic [3*DW-1:0] rd_data_top, rd_data_bot;
  logic [2:0]    rgb1, rgb2;
  logic          panel_clk, busy, done;

  always #5 clk = ~clk;

  bcm_row_shifter #(
    .MATRIX_WIDTH (W),
    .MATRIX_HEIGHT(H),
    .DATA_WIDTH   (DW),
    .MUX_LENGTH   (ML),
    .COL_BITS     (CB)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .mux_val        (mux_val),
    .current_bcm_bit(current_bcm_bit),
    .rd_addr        (rd_addr),
    .rd_data_top    (rd_data_top),
    .rd_data_bot    (rd_data_bot),
    .rgb1           (rgb1),
    .rgb2           (rgb2),
    .panel_clk      (panel_clk),
    .busy           (busy),
    .done           (done)
  );

  // Frame RAM model: one-cycle read latency, flat address = row*W + col.
  logic [3*DW-1:0] mem_top [0:(1<<AW)-1];
  logic [3*DW-1:0] mem_bot [0:(1<<AW)-1];

  always @(posedge clk) begin
    rd_data_top <= mem_top[rd_addr];
    rd_data_bot <= mem_bot[rd_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Colour channel bits of a pixel for bit plane b, by plain arithmetic.
  function automatic logic [2:0] ref_bits(input int unsigned px, input int unsigned b);
    int unsigned r, g, bl;
    if (b >= DW) return 3'b000;
    r  = (px >> (2 * DW + b)) & 1;
    g  = (px >> (DW + b)) & 1;
    bl = (px >> b) & 1;
    return {r[0], g[0], bl[0]};
  endfunction

  // Column shown at the k-th panel clock rise.
  function automatic int col_at(input int k);
`ifdef LED_SHIFT_REVERSE_EN
    return W - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic fill(input int mode);
    for (int a = 0; a < (1 << AW); a++) begin
      case (mode)
        0: begin
          mem_top[a] = 24'hFF0000;
          mem_bot[a] = 24'h0000FF;
        end
        1: begin
          mem_top[a] = 24'(a % W);          // B = column
          mem_bot[a] = 24'((a % W) << DW);  // G = column
        end
        default: begin
          mem_top[a] = 24'($urandom);
          mem_bot[a] = 24'($urandom);
        end
      endcase
    end
  endtask

  // One shift request; restart_at / rst_at < 0 disable the disturbances.
  task automatic do_shift(input int row, input int bitv, input int restart_at, input int rst_at);
    int rises = 0;
    int rises_after = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int col;
    logic prev_clk = 1'b0;
    logic exp_busy;
    int unsigned addr;

    @(negedge clk);
    mux_val = ML'(row);
    current_bcm_bit = DW'(bitv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mux_val = ML'($urandom);
    current_bcm_bit = DW'($urandom);

    for (int cyc = 1; cyc <= DONE_CYC + 6; cyc++) begin
      @(negedge clk);
      if (cyc == restart_at) begin
        start = 1'b1;
        mux_val = ML'(row ^ 5);
      end
      if (cyc == restart_at + 1) start = 1'b0;
      if (cyc == rst_at) begin
        n_rst = 1'b0;
        #1;
        chk("rst_rgb1", 32'(rgb1), 32'd0);
        chk("rst_rgb2", 32'(rgb2), 32'd0);
        chk("rst_pclk", 32'(panel_clk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
      end
      if (cyc == rst_at + 2) n_rst = 1'b1;

      if (rst_at >= 0 && cyc >= rst_at) exp_busy = 1'b0;
      else exp_busy = (cyc >= 1 && cyc <= DONE_CYC - 1);
      chk("busy", 32'(busy), 32'(exp_busy));

      if (busy) chk("row_field", 32'(rd_addr[AW-1:CB]), 32'(row));

      if (panel_clk && !prev_clk) begin
        if (rst_at >= 0 && cyc >= rst_at) begin
          rises_after++;
        end else begin
          if (rises < W) begin
            col  = col_at(rises);
            addr = 32'(row * W + col);
            chk("rgb1", 32'(rgb1), 32'(ref_bits(32'(mem_top[addr]), 32'(bitv))));
            chk("rgb2", 32'(rgb2), 32'(ref_bits(32'(mem_bot[addr]), 32'(bitv))));
          end
          rises++;
        end
      end
      prev_clk = panel_clk;

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

    if (rst_at < 0) begin
      chk("rise_count", 32'(rises), 32'(W));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'(DONE_CYC));
    end else begin
      chk("done_after_rst", 32'(done_cnt), 32'd0);
      chk("rises_after_rst", 32'(rises_after), 32'd0);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    mux_val = '0;
    current_bcm_bit = '0;
    fill(0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_pclk", 32'(panel_clk), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_rgb", 32'({rgb1, rgb2}), 32'd0);
      chk("idle_addr", 32'(rd_addr), 32'd0);
    end

    fill(0);
    do_shift(3, 7, -1, -1);

    fill(1);
    do_shift(int'($urandom_range(0, 15)), 0, -1, -1);

    fill(2);
    do_shift(int'($urandom_range(0, 15)), 8, -1, -1);
    do_shift(int'($urandom_range(0, 15)), 200, -1, -1);

    // Mid-shift restart attempt at 20, then reset at 50.
    fill(2);
    do_shift(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 20, 50);

    // start coinciding with done must be dropped.
    fill(2);
    do_shift(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), DONE_CYC, -1);

    for (int n = 0; n < 4; n++) begin
      fill(2);
      do_shift(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
